fifo_rx_sched: RTL and testbench

Round-robin scheduler that shares one `fifo_rx` read engine between NUM requesters. Each requester uses the same level fs/fd handshake and 16-bit length the engine uses. The scheduler grants one requester at a time, forwards that requester's length and start to the engine, and steers the engine's read strobe and done back to the granted requester. It sits between the packet consumers and the single `fifo_rx` instance on the receive FIFO.

---
 rtl/fifo_rx_sched.sv | 124 ++++++++++++
 tb/tb_fifo_rx_sched.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rx_sched.sv
// fifo_rx_sched: round-robin scheduler that shares one fifo_rx read engine
// among NUM requesters. It grants one requester at a time, forwards that
// requester's length and start to the engine, and steers the engine's read
// strobe and done back to the granted requester.
module fifo_rx_sched #(
    parameter int NUM = 4,
    parameter int IDW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM-1:0]    req_fs,
    output logic [NUM-1:0]    req_fd,
    input  logic [16*NUM-1:0] req_len,
    output logic [NUM-1:0]    req_rxen,
    output logic              rx_fs,
    input  logic              rx_fd,
    output logic [15:0]       rx_len,
    input  logic              rx_rxen,
    output logic              busy,
    output logic [IDW-1:0]    cur_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] ptr;
    logic           win_vld;
    logic [IDW-1:0] win_id;
    logic [15:0]    len_arr [NUM];

    // Unpack the flat length bus so a requester's length can be picked by index.
    for (genvar g = 0; g < NUM; g++) begin : g_len
        assign len_arr[g] = req_len[16*g +: 16];
    end

    // Round-robin search: first requester with fs high, starting at ptr and
    // wrapping at NUM (works for non-power-of-two NUM as well).
    always_comb begin
        logic [IDW-1:0] idx;
        // NOTE: every variable gets a default before any conditional write, so no path leaves it unassigned and no latch is inferred.
        win_vld = 1'b0;
        win_id  = '0;
        idx     = ptr;
        for (int k = 0; k < NUM; k++) begin
            if (!win_vld && req_fs[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
            end
            idx = (idx == IDW'(NUM - 1)) ? '0 : idx + 1'b1;
        end
    end

    // State register plus the grant pointer, current id and latched length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            cur_id <= '0;
            rx_len <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples the pre-edge values, independent of statement order.
            state <= state_nxt;
            if (state == ARB && win_vld) begin
                cur_id <= win_id;
                rx_len <= len_arr[win_id];
                ptr    <= (win_id == IDW'(NUM - 1)) ? '0 : win_id + 1'b1;
            end
        end
    end

    // Next-state logic. A zero length skips the engine entirely, since the
    // engine would treat zero as a full 65536-word read.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = ARB;
            ARB: begin
                if (win_vld) begin
                    state_nxt = (len_arr[win_id] == 16'd0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (rx_fd) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Leave only once the requester has released fs and the engine
                // has dropped done, so the engine is back in its wait state.
                if (!req_fs[cur_id] && !rx_fd) begin
                    state_nxt = ARB;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the registered state and cur_id.
    always_comb begin
        rx_fs    = 1'b0;
        busy     = 1'b0;
        req_fd   = '0;
        req_rxen = '0;
        case (state)
            BUSY: begin
                rx_fs            = 1'b1;
                busy             = 1'b1;
                req_rxen[cur_id] = rx_rxen;
            end
            DONE: begin
                busy           = 1'b1;
                req_fd[cur_id] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fifo_rx_sched.sv
// tb_fifo_rx_sched: self-checking bench for fifo_rx_sched. A behavioural
// fifo_rx engine answers the scheduler, a transaction-style reference model
// predicts every output each cycle, and directed plus random scenarios drive
// the requesters.
`timescale 1ns/1ps
module tb_fifo_rx_sched;

    localparam int NUM = 4;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM-1:0]    req_fs;
    logic [NUM-1:0]    req_fd;
    logic [16*NUM-1:0] req_len;
    logic [NUM-1:0]    req_rxen;
    logic              rx_fs;
    logic              rx_fd = 1'b0;
    logic [15:0]       rx_len;
    logic              rx_rxen = 1'b0;
    logic              busy;
    logic [IDW-1:0]    cur_id;
    logic [15:0]       len_tab [NUM];

    for (genvar g = 0; g < NUM; g++) begin : g_len
        assign req_len[16*g +: 16] = len_tab[g];
    end

    always #5 clk = ~clk;

    fifo_rx_sched #(.NUM(NUM), .IDW(IDW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_fs   (req_fs),
        .req_fd   (req_fd),
        .req_len  (req_len),
        .req_rxen (req_rxen),
        .rx_fs    (rx_fs),
        .rx_fd    (rx_fd),
        .rx_len   (rx_len),
        .rx_rxen  (rx_rxen),
        .busy     (busy),
        .cur_id   (cur_id)
    );

    // Behavioural fifo_rx engine: wait for fs, read rx_len words, hold done
    // until fs falls.
    int eng_st  = 0;
    int eng_cnt = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_st  <= 0;
            eng_cnt <= 0;
            rx_rxen <= 1'b0;
            rx_fd   <= 1'b0;
        end else begin
            case (eng_st)
                0: if (rx_fs) begin
                    eng_cnt <= (rx_len == 16'd0) ? 65536 : int'(rx_len);
                    rx_rxen <= 1'b1;
                    eng_st  <= 1;
                end
                1: if (eng_cnt <= 1) begin
                    rx_rxen <= 1'b0;
                    rx_fd   <= 1'b1;
                    eng_st  <= 2;
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
                default: if (!rx_fs) begin
                    rx_fd  <= 1'b0;
                    eng_st <= 0;
                end
            endcase
        end
    end

    // Reference model: who owns the engine, whether its transfer is finished,
    // the round-robin pointer and the granted length.
    bit m_boot  = 1'b1;
    int m_owner = -1;
    bit m_fin   = 1'b0;
    int m_ptr   = 0;
    int m_id    = 0;
    int m_len   = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_boot  = 1'b1;
            m_owner = -1;
            m_fin   = 1'b0;
            m_ptr   = 0;
            m_id    = 0;
            m_len   = 0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NUM; k++) begin
                int w;
                w = (m_ptr + k) % NUM;
                if (m_owner < 0 && req_fs[w]) begin
                    m_owner = w;
                    m_id    = w;
                    m_len   = int'(len_tab[w]);
                    m_ptr   = (w + 1) % NUM;
                    m_fin   = (m_len == 0);
                end
            end
        end else if (!m_fin) begin
            if (rx_fd) m_fin = 1'b1;
        end else if (!req_fs[m_id] && !rx_fd) begin
            m_owner = -1;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor state.
    int cyc       = 0;
    int rxen_cnt [NUM];
    int fs_cnt    = 0;
    int grants[$];
    bit prev_busy = 1'b0;
    int t_fd_rx   = -1;
    int t_fd_req  = -1;

    // Requester agent controls.
    bit ag_drop  = 1'b0;
    bit ag_rearm = 1'b0;
    bit ag_rand  = 1'b0;

    task automatic clear_mon();
        for (int i = 0; i < NUM; i++) rxen_cnt[i] = 0;
        fs_cnt   = 0;
        t_fd_rx  = -1;
        t_fd_req = -1;
        grants.delete();
    endtask

    task automatic agent_step();
        for (int i = 0; i < NUM; i++) begin
            if (req_fs[i] && req_fd[i] && ag_drop) begin
                if (!ag_rand || $urandom_range(0, 1) == 1) req_fs[i] = 1'b0;
            end else if (!req_fs[i] && !req_fd[i] && ag_rearm) begin
                if (!ag_rand || $urandom_range(0, 3) == 0) begin
                    req_fs[i] = 1'b1;
                    if (ag_rand) len_tab[i] = 16'($urandom_range(0, 6));
                end
            end else if (ag_rand && req_fs[i] && $urandom_range(0, 7) == 0) begin
                len_tab[i] = 16'($urandom_range(0, 6));
            end
        end
    endtask

    // One cycle: sample at the falling edge, compare with the model, then
    // let the requester agent react.
    task automatic tick();
        logic [31:0] e_fs, e_busy, e_fd, e_rxen;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NUM; i++) if (req_rxen[i]) rxen_cnt[i]++;
        if (rx_fs) fs_cnt++;
        if (busy && !prev_busy) grants.push_back(int'(cur_id));
        prev_busy = busy;
        if (rx_fd && t_fd_rx < 0) t_fd_rx = cyc;
        if (req_fd != '0 && t_fd_req < 0) t_fd_req = cyc;

        e_busy = 32'(m_owner >= 0);
        e_fs   = 32'(m_owner >= 0 && !m_fin);
        e_fd   = (m_owner >= 0 && m_fin) ? (32'd1 << m_id) : 32'd0;
        e_rxen = (m_owner >= 0 && !m_fin && rx_rxen) ? (32'd1 << m_id) : 32'd0;
        check("busy",     32'(busy),     e_busy);
        check("rx_fs",    32'(rx_fs),    e_fs);
        check("req_fd",   32'(req_fd),   e_fd);
        check("req_rxen", 32'(req_rxen), e_rxen);
        check("cur_id",   32'(cur_id),   m_id);
        check("rx_len",   32'(rx_len),   m_len);
        agent_step();
    endtask

    task automatic wait_busy(input logic v, input string tag);
        int n = 0;
        while (busy !== v && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_wait_busy"}, 32'(busy === v), 32'd1);
    endtask

    task automatic wait_rxen(input int idx, input int cnt, input string tag);
        int n = 0;
        while (rxen_cnt[idx] < cnt && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_wait_rxen"}, 32'(rxen_cnt[idx] >= cnt), 32'd1);
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        while ((req_fs !== '0 || busy !== 1'b0) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_drain"}, 32'(req_fs === '0 && busy === 1'b0), 32'd1);
    endtask

    initial begin
        int exp_order [6];
        exp_order = '{0, 1, 2, 3, 0, 1};

        rst    = 1'b1;
        req_fs = '1;
        for (int i = 0; i < NUM; i++) len_tab[i] = 16'd3;
        clear_mon();

        // Reset held with everyone requesting: all outputs stay 0.
        repeat (3) begin
            tick();
            check("rst_outputs", {22'd0, rx_fs, busy, req_fd, req_rxen}, 32'd0);
            check("rst_regs", {14'd0, cur_id, rx_len}, 32'd0);
        end

        // Release: one IDLE cycle, one ARB cycle, then grant to 0.
        // Fairness continues from here with every requester re-raising.
        ag_drop  = 1'b1;
        ag_rearm = 1'b1;
        rst      = 1'b0;
        tick();
        check("boot_idle", 32'(busy), 32'd0);
        tick();
        check("boot_first_busy", 32'(busy), 32'd1);
        check("boot_first_id", 32'(cur_id), 32'd0);
        begin
            int n = 0;
            while (grants.size() < 6 && n < 400) begin
                tick();
                n++;
            end
        end
        check("rr_grant_count", 32'(grants.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < grants.size(); i++) begin
            check($sformatf("rr_grant%0d", i), grants[i], exp_order[i]);
        end
        ag_rearm = 1'b0;
        wait_drain(300, "rr");

        // Single transfer on requester 2, length 5.
        clear_mon();
        len_tab[2] = 16'd5;
        req_fs[2]  = 1'b1;
        wait_busy(1'b1, "single_start");
        check("single_id", 32'(cur_id), 32'd2);
        check("single_len", 32'(rx_len), 32'd5);
        wait_busy(1'b0, "single_end");
        check("single_rxen2", rxen_cnt[2], 32'd5);
        check("single_rxen_other", rxen_cnt[0] + rxen_cnt[1] + rxen_cnt[3], 32'd0);
        check("single_fd_latency", t_fd_req - t_fd_rx, 32'd1);

        // Zero length on requester 1: engine never started, pointer moves to 2.
        clear_mon();
        len_tab[1] = 16'd0;
        req_fs[1]  = 1'b1;
        wait_busy(1'b1, "zero_start");
        check("zero_id", 32'(cur_id), 32'd1);
        check("zero_fd_now", 32'(req_fd), 32'b0010);
        wait_busy(1'b0, "zero_end");
        check("zero_rx_fs_never", fs_cnt, 32'd0);
        for (int i = 0; i < NUM; i++) len_tab[i] = 16'd3;
        req_fs = '1;
        wait_busy(1'b1, "zero_next");
        check("zero_next_grant", 32'(cur_id), 32'd2);
        wait_drain(300, "zero");

        // Early drop: requester 3 releases fs midway through a length-8 read.
        clear_mon();
        len_tab[3] = 16'd8;
        req_fs[3]  = 1'b1;
        wait_busy(1'b1, "drop_start");
        check("drop_id", 32'(cur_id), 32'd3);
        wait_rxen(3, 4, "drop_mid");
        req_fs[3] = 1'b0;
        wait_busy(1'b0, "drop_end");
        check("drop_reads", rxen_cnt[3], 32'd8);
        check("drop_fd_seen", 32'(t_fd_req >= 0), 32'd1);

        // Reset in the middle of a length-10 transfer on requester 2.
        clear_mon();
        len_tab[2] = 16'd10;
        req_fs[2]  = 1'b1;
        wait_busy(1'b1, "mrst_start");
        wait_rxen(2, 3, "mrst_mid");
        check("mrst_pre_fs", 32'(rx_fs), 32'd1);
        rst = 1'b1;
        #1;
        check("mrst_fs_drop", 32'(rx_fs), 32'd0);
        check("mrst_rxen_drop", 32'(req_rxen), 32'd0);
        check("mrst_busy_drop", 32'(busy), 32'd0);
        req_fs = '1;
        for (int i = 0; i < NUM; i++) len_tab[i] = 16'd2;
        tick();
        tick();
        rst = 1'b0;
        wait_busy(1'b1, "mrst_after");
        check("mrst_first_grant", 32'(cur_id), 32'd0);
        wait_drain(300, "mrst");

        // Random traffic: random lengths (including 0), random hold after
        // done, lengths changing while requested.
        ag_rand  = 1'b1;
        ag_rearm = 1'b1;
        repeat (1500) tick();
        ag_rearm = 1'b0;
        wait_drain(600, "rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard stop in case something stalls outside the bounded waits.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
